dma_desc_issuer: RTL

CSR initiator that programs the DMA descriptor register file on behalf of the L1 scheduler. It accepts descriptors on a valid/ready interface and polls STAT until the DMA CSR FIFO has room. It then writes SRC, DST and LEN, and finally writes CFG to push the descriptor. Error status found during polling is captured and reported upward, and the block halts until the error is cleared.

---
 rtl/dma_pkg.sv | 48 ++++
 rtl/venus_soc_pkg.sv | 18 +
 rtl/dma_desc_issuer_if.sv | 33 +++
 rtl/dma_desc_issuer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// DMA register map, STAT bit positions, descriptor field types and the
// descriptor issuer state encoding.
package dma_pkg;

  typedef logic [31:0] desc_addr_t;
  typedef logic [15:0] desc_num_t;
  typedef logic [1:0]  err_src_t;

  // CSR offsets, ORed into the low address bits of the DMA base.
  localparam logic [5:0] CSR_CFG     = 6'h00;
  localparam logic [5:0] CSR_SRC     = 6'h08;
  localparam logic [5:0] CSR_DST     = 6'h10;
  localparam logic [5:0] CSR_LEN     = 6'h18;
  localparam logic [5:0] CSR_STAT    = 6'h20;
  localparam logic [5:0] CSR_ERRADDR = 6'h28;

  // STAT register bits.
  localparam int unsigned STAT_ERR_BIT  = 0;
  localparam int unsigned STAT_FULL_BIT = 1;
  localparam int unsigned STAT_SRC_LSB  = 2;

  // Position of each register inside csr_rdata.
  localparam int unsigned RDATA_CFG_LSB     = 0;
  localparam int unsigned RDATA_SRC_LSB     = 32;
  localparam int unsigned RDATA_DST_LSB     = 64;
  localparam int unsigned RDATA_LEN_LSB     = 96;
  localparam int unsigned RDATA_STAT_LSB    = 128;
  localparam int unsigned RDATA_ERRADDR_LSB = 160;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_POLL_RD   = 4'd1,
    ST_POLL_WAIT = 4'd2,
    ST_WR_SRC    = 4'd3,
    ST_WR_DST    = 4'd4,
    ST_WR_LEN    = 4'd5,
    ST_WR_CFG    = 4'd6,
    ST_SETTLE    = 4'd7,
    ST_ERR       = 4'd8
  } dma_state_e;

  // Full CSR address of a DMA register.
  function automatic logic [31:0] csr_addr(input logic [31:0] base,
                                           input logic [5:0]  off);
    return base | {26'b0, off};
  endfunction

endpackage

// File: rtl/venus_soc_pkg.sv
// SoC-wide CSR bus types shared by every CSR initiator and target.
package venus_soc_pkg;

  // One CSR request beat. A read returns the whole register bank on
  // csr_rdata one cycle later, so rd_en carries no address.
  typedef struct packed {
    logic        wr_en;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        rd_en;
  } csr_req_t;

  // Register bank snapshot, six 32-bit registers packed low to high.
  typedef struct packed {
    logic [191:0] csr_rdata;
  } csr_resp_t;

endpackage

// File: rtl/dma_desc_issuer_if.sv
// Descriptor handshake plus DMA CSR bus of the descriptor issuer.
//
// Handshake: the upstream raises desc_valid_i with stable fields and holds
// them until a rising clk edge where desc_valid_i && desc_ready_o; that edge
// transfers the descriptor. desc_ready_o does not depend on desc_valid_i.
interface dma_desc_issuer_if;
  import venus_soc_pkg::*;
  import dma_pkg::*;

  logic       desc_valid_i;
  logic       desc_ready_o;
  desc_addr_t desc_src_i;
  desc_addr_t desc_dst_i;
  desc_num_t  desc_len_i;
  logic       desc_last_i;
  csr_req_t   dma_csr_req_o;
  csr_resp_t  dma_csr_resp_i;

  // Issuer side.
  modport slave (
    input  desc_valid_i, desc_src_i, desc_dst_i, desc_len_i, desc_last_i,
    input  dma_csr_resp_i,
    output desc_ready_o, dma_csr_req_o
  );

  // Scheduler / DMA model side.
  modport master (
    output desc_valid_i, desc_src_i, desc_dst_i, desc_len_i, desc_last_i,
    output dma_csr_resp_i,
    input  desc_ready_o, dma_csr_req_o
  );

endinterface

// File: rtl/dma_desc_issuer.sv
// Programs one DMA descriptor at a time: poll STAT until the CSR FIFO has
// room, write SRC/DST/LEN, then CFG to push. A DMA error seen while polling
// is latched and the block parks in ERR until err_clear_i.
module dma_desc_issuer
  import venus_soc_pkg::*;
  import dma_pkg::*;
#(
  parameter logic [31:0] DMA_CSR_BASE  = 32'h0,
  // Quiet cycles after a CFG write; valid range 2..15.
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rstn,
  dma_desc_issuer_if.slave  bus,
  input  logic              err_clear_i,
  output logic              busy_o,
  output logic              err_valid_o,
  output logic [31:0]       err_addr_o,
  output err_src_t          err_src_o,
  output logic [15:0]       issued_cnt_o,
  output dma_state_e        state_o
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  dma_state_e  state_q, state_d;
  desc_addr_t  src_q, src_d;
  desc_addr_t  dst_q, dst_d;
  desc_num_t   len_q, len_d;
  logic        last_q, last_d;
  logic [3:0]  settle_q, settle_d;
  csr_req_t    req_q, req_d;
  logic        err_valid_q, err_valid_d;
  logic [31:0] err_addr_q, err_addr_d;
  err_src_t    err_src_q, err_src_d;
  logic [15:0] issued_cnt_q, issued_cnt_d;

  logic [31:0] stat_w;
  logic [31:0] erraddr_w;
  logic        unused_rdata;

  assign stat_w    = bus.dma_csr_resp_i.csr_rdata[RDATA_STAT_LSB +: 32];
  assign erraddr_w = bus.dma_csr_resp_i.csr_rdata[RDATA_ERRADDR_LSB +: 32];
  // Only STAT[3:0] and ERRADDR matter to the issuer.
  assign unused_rdata = ^{bus.dma_csr_resp_i.csr_rdata[RDATA_STAT_LSB-1:0],
                          stat_w[31:4]};

  // Next-state, descriptor latch, error capture and push counter.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    last_d       = last_q;
    settle_d     = settle_q;
    err_valid_d  = err_valid_q;
    err_addr_d   = err_addr_q;
    err_src_d    = err_src_q;
    issued_cnt_d = issued_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.desc_valid_i) begin
          src_d   = bus.desc_src_i;
          dst_d   = bus.desc_dst_i;
          len_d   = bus.desc_len_i;
          last_d  = bus.desc_last_i;
          state_d = ST_POLL_RD;
        end
      end
      ST_POLL_RD: state_d = ST_POLL_WAIT;
      ST_POLL_WAIT: begin
        if (stat_w[STAT_ERR_BIT]) begin
          err_valid_d = 1'b1;
          err_addr_d  = erraddr_w;
          err_src_d   = stat_w[STAT_SRC_LSB +: 2];
          state_d     = ST_ERR;
        end else if (stat_w[STAT_FULL_BIT]) begin
          state_d = ST_POLL_RD;
        end else begin
          state_d = ST_WR_SRC;
        end
      end
      ST_WR_SRC: state_d = ST_WR_DST;
      ST_WR_DST: state_d = ST_WR_LEN;
      ST_WR_LEN: state_d = ST_WR_CFG;
      ST_WR_CFG: begin
        issued_cnt_d = issued_cnt_q + 16'd1;
        settle_d     = SETTLE_LOAD;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        // The DMA needs a write-free cycle to drop its start bit and two
        // cycles for the FIFO-full flag to catch up with the push.
        if (settle_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      ST_ERR: begin
        if (err_clear_i) begin
          err_valid_d = 1'b0;
          err_addr_d  = 32'h0;
          err_src_d   = 2'b00;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CSR request for the cycle the FSM is about to enter, so the bus is
  // driven straight from flops and lines up with the registered state.
  always_comb begin
    req_d = '0;
    case (state_d)
      ST_POLL_RD: req_d.rd_en = 1'b1;
      ST_WR_SRC: begin
        req_d.wr_en = 1'b1;
        req_d.waddr = csr_addr(DMA_CSR_BASE, CSR_SRC);
        req_d.wdata = src_q;
      end
      ST_WR_DST: begin
        req_d.wr_en = 1'b1;
        req_d.waddr = csr_addr(DMA_CSR_BASE, CSR_DST);
        req_d.wdata = dst_q;
      end
      ST_WR_LEN: begin
        req_d.wr_en = 1'b1;
        req_d.waddr = csr_addr(DMA_CSR_BASE, CSR_LEN);
        req_d.wdata = 32'(len_q);
      end
      ST_WR_CFG: begin
        // Bit 0 starts the push, bit 1 marks the last scatter block.
        req_d.wr_en = 1'b1;
        req_d.waddr = csr_addr(DMA_CSR_BASE, CSR_CFG);
        req_d.wdata = {30'b0, last_q, 1'b1};
      end
      default: req_d = '0;
    endcase
  end

  // State and datapath registers; reset abandons any partial descriptor.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      last_q       <= 1'b0;
      settle_q     <= 4'd0;
      req_q        <= '0;
      err_valid_q  <= 1'b0;
      err_addr_q   <= 32'h0;
      err_src_q    <= 2'b00;
      issued_cnt_q <= 16'h0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      last_q       <= last_d;
      settle_q     <= settle_d;
      req_q        <= req_d;
      err_valid_q  <= err_valid_d;
      err_addr_q   <= err_addr_d;
      err_src_q    <= err_src_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  assign bus.desc_ready_o  = (state_q == ST_IDLE);
  assign bus.dma_csr_req_o = req_q;
  assign busy_o            = (state_q != ST_IDLE);
  assign err_valid_o       = err_valid_q;
  assign err_addr_o        = err_addr_q;
  assign err_src_o         = err_src_q;
  assign issued_cnt_o      = issued_cnt_q;
  assign state_o           = state_q;

endmodule
